cmp_stream_monitor: RTL
=======================

// Module: cmp_stream_monitor
// PURPOSE
//  Sequential stage placed directly downstream of the 4-bit magnitude comparator.
//  - Consumes the comparator's aeqb/agtb/altb flags for each valid operand pair.
//  - Keeps saturating counts of greater/less/equal results.
//  - Tracks the current run of consecutive equal results.
//  - Locks when the run reaches EQ_RUN, and records the direction of the last result.
// PARAMETERS
//  CNT_W   8  width of each result counter; counters saturate at 2**CNT_W-1
//  EQ_RUN  4  consecutive equal results needed to enter LOCKED (legal range 1..15)
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous reset, active-high
//  clear      in   1      synchronous soft clear; same effect as rst
//  in_valid   in   1      comparator flags below are valid this cycle
//  in_aeqb    in   1      comparator a==b
//  in_agtb    in   1      comparator a>b
//  in_altb    in   1      comparator a<b
//  gt_cnt     out  CNT_W  number of a>b results accepted
//  lt_cnt     out  CNT_W  number of a<b results accepted
//  eq_cnt     out  CNT_W  number of a==b results accepted
//  eq_run     out  4      current consecutive-equal run length, saturates at EQ_RUN
//  last_dir   out  2      last accepted result: 00 none, 01 lt, 10 gt, 11 eq
//  locked     out  1      high while FSM is in LOCKED
//  lock_pulse out  1      one-cycle pulse on the cycle locked first rises
//  err        out  1      sticky flag-encoding error (only with CMP_ONEHOT_CHECK_EN)
// BEHAVIOUR
//  - Reset/clear: all counters, eq_run, last_dir=00, locked, lock_pulse and err go to 0.
//    FSM goes to IDLE. rst has priority over clear.
//    clear in the same cycle as in_valid discards that sample.
//  - Latency: a sample accepted at edge N is visible on all outputs after edge N.
//    There is no backpressure; every in_valid cycle is a sample.
//  - Decode without the macro: priority eq > gt > lt.
//    All three flags low with in_valid high: sample ignored, no state change.
//  - FSM states: IDLE, TRACK, LOCKED.
//    IDLE -> TRACK on the first accepted sample, or directly to LOCKED if EQ_RUN==1 and the sample is eq.
//    TRACK -> LOCKED when an eq sample makes eq_run reach EQ_RUN.
//    LOCKED -> TRACK on any accepted gt/lt sample.
//    LOCKED stays LOCKED on further eq samples; eq_run holds at EQ_RUN.
//    in_valid low: state and all outputs hold, except lock_pulse returns to 0.
//  - eq_run update: eq sample gives min(eq_run+1, EQ_RUN); gt/lt sample gives 0.
//  - Counters: increment by 1 per matching sample; hold at all-ones (no wrap).
//  - lock_pulse: high exactly one cycle, registered with the transition into LOCKED.
//    Leaving and re-entering LOCKED produces a new pulse.
//  - Outputs are registered; there are no combinational paths from inputs to outputs.
// CONFIGURATION
//  Macro CMP_ONEHOT_CHECK_EN:
//  - Defined: a sample whose flags are not exactly one-hot (including all-zero) is dropped.
//    It sets err=1, and err stays 1 until rst/clear. Counters, eq_run, FSM and last_dir are untouched.
//  - Undefined: the priority decode above applies; the err port still exists and is tied to 0.
// TESTING
//  1 rst=1 while outputs are nonzero -> next cycle all counters=0, last_dir=00, locked=0.
//  2 Samples gt,lt,gt -> gt_cnt=2, lt_cnt=1, eq_cnt=0, last_dir=10, eq_run=0.
//  3 EQ_RUN=4, four eq samples -> locked rises after the 4th edge, lock_pulse high exactly one cycle.
//    A 5th eq keeps locked=1 with no pulse; a following lt gives locked=0, eq_run=0.
//  4 CNT_W=2, five gt samples -> gt_cnt sequence 1,2,3,3,3.
//  5 clear and in_valid(eq) together after 3 eqs -> all zero, FSM IDLE, sample not counted.
//  6 Flags 110 with in_valid: macro on -> err=1, counts unchanged.
//    Macro off -> eq_cnt+1, last_dir=11.

Source files
------------

// File: rtl/cmp_stream_monitor.sv
// cmp_stream_monitor
//   Sits downstream of a 4-bit magnitude comparator. For each valid sample it:
//   - keeps saturating counts of gt/lt/eq results,
//   - tracks the current run of consecutive eq results,
//   - locks (IDLE/TRACK/LOCKED FSM) once the run reaches EQ_RUN,
//   - records the direction of the last accepted result.
//   All outputs are registered. EQ_RUN must be in 1..15.
//   Optional feature macro: CMP_ONEHOT_CHECK_EN. When it is defined, samples whose
//   flags are not exactly one-hot are dropped and raise a sticky err. When it is
//   undefined, flags use priority decode eq > gt > lt and err stays 0.
module cmp_stream_monitor #(
    parameter int CNT_W  = 8,
    parameter int EQ_RUN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_aeqb,
    input  logic             in_agtb,
    input  logic             in_altb,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [3:0]       eq_run,
    output logic [1:0]       last_dir,
    output logic             locked,
    output logic             lock_pulse,
    output logic             err
);

    typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_LOCKED} state_t;
    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_LT   = 2'b01,
        DIR_GT   = 2'b10,
        DIR_EQ   = 2'b11
    } dir_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       RUN_MAX = 4'(EQ_RUN);

    state_t           state_q, state_d;
    dir_t             last_dir_q, last_dir_d;
    logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
    logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic [3:0]       eq_run_q, eq_run_d, run_next;
    logic             lock_pulse_q, lock_pulse_d;
    logic             err_q, err_d;

    logic is_eq, is_gt, is_lt, flag_bad;

`ifdef CMP_ONEHOT_CHECK_EN
    logic onehot;
    // Strict decode: accept only exactly one asserted flag; anything else is an error.
    always_comb begin
        // Odd parity with not-all-three-set means exactly one flag is high.
        onehot   = (in_aeqb ^ in_agtb ^ in_altb) & ~(in_aeqb & in_agtb & in_altb);
        is_eq    = in_valid & onehot & in_aeqb;
        is_gt    = in_valid & onehot & in_agtb;
        is_lt    = in_valid & onehot & in_altb;
        flag_bad = in_valid & ~onehot;
    end
`else
    // Priority decode eq > gt > lt; all-zero flags give no sample.
    always_comb begin
        is_eq    = in_valid & in_aeqb;
        is_gt    = in_valid & ~in_aeqb & in_agtb;
        is_lt    = in_valid & ~in_aeqb & ~in_agtb & in_altb;
        flag_bad = 1'b0;
    end
`endif

    // Next-state logic for FSM, counters, run length, direction and pulse.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        last_dir_d   = last_dir_q;
        gt_cnt_d     = gt_cnt_q;
        lt_cnt_d     = lt_cnt_q;
        eq_cnt_d     = eq_cnt_q;
        eq_run_d     = eq_run_q;
        err_d        = err_q | flag_bad;
        run_next     = (eq_run_q >= RUN_MAX) ? RUN_MAX : eq_run_q + 4'd1;

        if (is_eq) begin
            eq_run_d   = run_next;
            last_dir_d = DIR_EQ;
            eq_cnt_d   = (eq_cnt_q == CNT_MAX) ? eq_cnt_q : eq_cnt_q + CNT_W'(1);
            state_d    = (run_next == RUN_MAX) ? ST_LOCKED : ST_TRACK;
        end else if (is_gt || is_lt) begin
            eq_run_d = 4'd0;
            state_d  = ST_TRACK;
            if (is_gt) begin
                last_dir_d = DIR_GT;
                gt_cnt_d   = (gt_cnt_q == CNT_MAX) ? gt_cnt_q : gt_cnt_q + CNT_W'(1);
            end else begin
                last_dir_d = DIR_LT;
                lt_cnt_d   = (lt_cnt_q == CNT_MAX) ? lt_cnt_q : lt_cnt_q + CNT_W'(1);
            end
        end

        // Pulse only on the edge into LOCKED; idle or dropped cycles return it to 0.
        lock_pulse_d = (state_d == ST_LOCKED) && (state_q != ST_LOCKED);
    end

    // State register with synchronous reset; clear acts exactly like rst and discards the sample.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q      <= ST_IDLE;
            last_dir_q   <= DIR_NONE;
            gt_cnt_q     <= '0;
            lt_cnt_q     <= '0;
            eq_cnt_q     <= '0;
            eq_run_q     <= '0;
            lock_pulse_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            last_dir_q   <= last_dir_d;
            gt_cnt_q     <= gt_cnt_d;
            lt_cnt_q     <= lt_cnt_d;
            eq_cnt_q     <= eq_cnt_d;
            eq_run_q     <= eq_run_d;
            lock_pulse_q <= lock_pulse_d;
            err_q        <= err_d;
        end
    end

    assign gt_cnt     = gt_cnt_q;
    assign lt_cnt     = lt_cnt_q;
    assign eq_cnt     = eq_cnt_q;
    assign eq_run     = eq_run_q;
    assign last_dir   = last_dir_q;
    assign locked     = (state_q == ST_LOCKED);
    assign lock_pulse = lock_pulse_q;
    assign err        = err_q;

endmodule
